// File: rtl/gpu_pkg.sv
// Shared sizing constants and line-state encoding for the FMA write buffer.
package gpu_pkg;

    localparam int FMA_COUNT  = 2;
    localparam int WORD_WIDTH = 16;
    localparam int SLOTS      = 3;
    localparam int LINE_WIDTH = 96;

    localparam int BEAT_W = FMA_COUNT * WORD_WIDTH;
    localparam int CNT_W  = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } wbuf_state_e;

endpackage

// File: rtl/fma_write_buffer_if.sv
// Bus between the FMA array / memory controller and the write buffer.
interface fma_write_buffer_if;
    import gpu_pkg::*;

    logic [BEAT_W-1:0]     fma_result_in;
    logic                  fma_valid_in;
    logic                  flush_in;
    logic                  read_ack_in;
    logic [LINE_WIDTH-1:0] write_buffer_read_out;
    logic                  write_buffer_valid_out;
    logic [CNT_W-1:0]      fill_count_out;
    logic                  overflow_out;

    modport master (
        output fma_result_in, fma_valid_in, flush_in, read_ack_in,
        input  write_buffer_read_out, write_buffer_valid_out, fill_count_out, overflow_out
    );

    modport slave (
        input  fma_result_in, fma_valid_in, flush_in, read_ack_in,
        output write_buffer_read_out, write_buffer_valid_out, fill_count_out, overflow_out
    );

endinterface

// File: rtl/fma_write_buffer_bank.sv
// One line register with its slot counter, zero-fill on flush and an optional
// load path used to promote a back line into this bank.
module write_line_bank
    import gpu_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en,
    input  logic [BEAT_W-1:0]     wr_data,
    input  logic                  flush_en,
    input  logic                  release_en,
    input  logic                  load_en,
    input  wbuf_state_e           load_state,
    input  logic [CNT_W-1:0]      load_count,
    input  logic [LINE_WIDTH-1:0] load_line,
    output wbuf_state_e           state,
    output logic [CNT_W-1:0]      count,
    output logic [LINE_WIDTH-1:0] line
);

    wbuf_state_e           state_p0, state_n, state_b;
    logic [CNT_W-1:0]      cnt_p0, cnt_n, cnt_b, cnt_w;
    logic [LINE_WIDTH-1:0] line_p0, line_n, line_b;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_p0 <= EMPTY;
            cnt_p0   <= '0;
            line_p0  <= '0;
        end else begin
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
            line_p0  <= line_n;
        end
    end

    always_comb begin
        state_b = state_p0;
        cnt_b   = cnt_p0;
        line_b  = line_p0;
        // Released slots keep their old data until a new beat lands on them.
        if (load_en) begin
            state_b = load_state;
            cnt_b   = load_count;
            line_b  = load_line;
        end else if (release_en) begin
            state_b = EMPTY;
            cnt_b   = '0;
        end

        state_n = state_b;
        cnt_n   = cnt_b;
        line_n  = line_b;
        cnt_w   = cnt_b;
        if (state_b != FULL) begin
            if (wr_en) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (CNT_W'(s) == cnt_b) line_n[s*BEAT_W +: BEAT_W] = wr_data;
                end
                cnt_w = cnt_b + 1'b1;
            end
            if (cnt_w == CNT_W'(SLOTS) || (flush_en && cnt_w != '0)) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (CNT_W'(s) >= cnt_w) line_n[s*BEAT_W +: BEAT_W] = '0;
                end
                state_n = FULL;
                cnt_n   = '0;
            end else begin
                cnt_n   = cnt_w;
                state_n = (cnt_w != '0) ? FILLING : EMPTY;
            end
        end
    end

    assign state = state_p0;
    assign count = cnt_p0;
    assign line  = line_p0;

endmodule

// File: rtl/fma_write_buffer.sv
// Packs FMA result beats into lines for memory. Optional back line for
// double buffering is enabled with FMA_WRITE_BUFFER_DOUBLE_EN.
module fma_write_buffer
    import gpu_pkg::*;
(
    input logic               clk_in,
    input logic               rst_in,
    fma_write_buffer_if.slave bus
);

    if (LINE_WIDTH != SLOTS * BEAT_W) begin : g_width_check
        $error("LINE_WIDTH must equal SLOTS*FMA_COUNT*WORD_WIDTH");
    end

    wbuf_state_e           f_state;
    logic [CNT_W-1:0]      f_count;
    logic [LINE_WIDTH-1:0] f_line;
    logic                  f_full, rel, f_base_full, drop, ovf_p0;
    logic                  f_load_en;
    wbuf_state_e           f_load_state;
    logic [CNT_W-1:0]      f_load_count;
    logic [LINE_WIDTH-1:0] f_load_line;

    assign f_full = (f_state == FULL);
    assign rel    = bus.read_ack_in & f_full;

`ifdef FMA_WRITE_BUFFER_DOUBLE_EN
    wbuf_state_e           b_state;
    logic [CNT_W-1:0]      b_count;
    logic [LINE_WIDTH-1:0] b_line;
    logic                  b_full, b_base_full;

    // f_base_full/b_base_full describe each bank after this cycle's release.
    assign b_full       = (b_state == FULL);
    assign f_load_en    = rel & (b_state != EMPTY);
    assign f_load_state = b_state;
    assign f_load_count = b_count;
    assign f_load_line  = b_line;
    assign f_base_full  = rel ? b_full : f_full;
    assign b_base_full  = b_full & ~rel;
    assign drop         = bus.fma_valid_in & f_base_full & b_base_full;

    write_line_bank u_back (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_en      (bus.fma_valid_in & f_base_full),
        .wr_data    (bus.fma_result_in),
        .flush_en   (bus.flush_in & f_base_full),
        .release_en (rel),
        .load_en    (1'b0),
        .load_state (EMPTY),
        .load_count ('0),
        .load_line  ('0),
        .state      (b_state),
        .count      (b_count),
        .line       (b_line)
    );

    assign bus.fill_count_out = f_full ? b_count : f_count;
`else
    assign f_load_en    = 1'b0;
    assign f_load_state = EMPTY;
    assign f_load_count = '0;
    assign f_load_line  = '0;
    assign f_base_full  = f_full & ~rel;
    assign drop         = bus.fma_valid_in & f_base_full;

    assign bus.fill_count_out = f_count;
`endif

    write_line_bank u_front (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_en      (bus.fma_valid_in & ~f_base_full),
        .wr_data    (bus.fma_result_in),
        .flush_en   (bus.flush_in & ~f_base_full),
        .release_en (rel),
        .load_en    (f_load_en),
        .load_state (f_load_state),
        .load_count (f_load_count),
        .load_line  (f_load_line),
        .state      (f_state),
        .count      (f_count),
        .line       (f_line)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) ovf_p0 <= 1'b0;
        else if (drop) ovf_p0 <= 1'b1;
    end

    assign bus.write_buffer_read_out  = f_line;
    assign bus.write_buffer_valid_out = f_full;
    assign bus.overflow_out           = ovf_p0;

endmodule

// File: tb/tb_fma_write_buffer.sv
// Randomized and directed bench for fma_write_buffer against a line-level model.
module tb_fma_write_buffer;
    import gpu_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    fma_write_buffer_if bus();

    fma_write_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] got,
                       input logic [LINE_WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: one line being built in place, plus a presented/complete flag.
    logic [LINE_WIDTH-1:0] m_line;
    int                    m_cnt;
    bit                    m_full;
    bit                    m_ovf;

    task automatic model_reset();
        m_line = '0;
        m_cnt  = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit beat, input logic [BEAT_W-1:0] d,
                              input bit fl, input bit ack);
        if (m_full && ack) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end else if (m_full && beat) begin
            m_ovf = 1'b1;
        end
        if (!m_full) begin
            if (beat) begin
                m_line[m_cnt*BEAT_W +: BEAT_W] = d;
                m_cnt++;
            end
            if (m_cnt == SLOTS || (fl && m_cnt > 0)) begin
                for (int k = m_cnt; k < SLOTS; k++) m_line[k*BEAT_W +: BEAT_W] = '0;
                m_full = 1'b1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_line"},  bus.write_buffer_read_out, m_line);
        chk({tag, "_valid"}, LINE_WIDTH'(bus.write_buffer_valid_out), LINE_WIDTH'(m_full));
        chk({tag, "_cnt"},   LINE_WIDTH'(bus.fill_count_out), LINE_WIDTH'(m_cnt));
        chk({tag, "_ovf"},   LINE_WIDTH'(bus.overflow_out), LINE_WIDTH'(m_ovf));
    endtask

    task automatic drive(input bit beat, input logic [BEAT_W-1:0] d,
                         input bit fl, input bit ack);
        bus.fma_valid_in  = beat;
        bus.fma_result_in = d;
        bus.flush_in      = fl;
        bus.read_ack_in   = ack;
        @(posedge clk_in);
        #1;
        bus.fma_valid_in = 1'b0;
        bus.flush_in     = 1'b0;
        bus.read_ack_in  = 1'b0;
        model_step(beat, d, fl, ack);
    endtask

    task automatic do_reset();
        rst_in            = 1'b0;
        bus.fma_valid_in  = 1'b0;
        bus.fma_result_in = '0;
        bus.flush_in      = 1'b0;
        bus.read_ack_in   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    function automatic logic [BEAT_W-1:0] bt(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

    initial begin
        rst_in = 1'b0;
        do_reset();
        chk("rst_line",  bus.write_buffer_read_out, '0);
        chk("rst_valid", LINE_WIDTH'(bus.write_buffer_valid_out), '0);
        chk("rst_cnt",   LINE_WIDTH'(bus.fill_count_out), '0);
        chk("rst_ovf",   LINE_WIDTH'(bus.overflow_out), '0);

`ifdef FMA_WRITE_BUFFER_DOUBLE_EN
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bt(16'(2*i+2), 16'(2*i+1)), 1'b0, 1'b0);
            if (i == 2) chk("dbl_valid3", LINE_WIDTH'(bus.write_buffer_valid_out), 1);
            if (i == 3) chk("dbl_backcnt", LINE_WIDTH'(bus.fill_count_out), 1);
        end
        chk("dbl_valid6", LINE_WIDTH'(bus.write_buffer_valid_out), 1);
        chk("dbl_line1",  bus.write_buffer_read_out, 96'h0006_0005_0004_0003_0002_0001);
        chk("dbl_ovf6",   LINE_WIDTH'(bus.overflow_out), 0);
        drive(1'b1, bt(16'hDEAD, 16'hBEEF), 1'b0, 1'b0);
        chk("dbl_ovf7",   LINE_WIDTH'(bus.overflow_out), 1);
        chk("dbl_line1b", bus.write_buffer_read_out, 96'h0006_0005_0004_0003_0002_0001);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("dbl_valid_prom", LINE_WIDTH'(bus.write_buffer_valid_out), 1);
        chk("dbl_line2",  bus.write_buffer_read_out, 96'h000C_000B_000A_0009_0008_0007);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("dbl_valid_end", LINE_WIDTH'(bus.write_buffer_valid_out), 0);
`else
        // Three beats make a full line.
        drive(1'b1, bt(16'h0002, 16'h0001), 1'b0, 1'b0);
        check_model("b1");
        chk("b1_cnt_const", LINE_WIDTH'(bus.fill_count_out), 1);
        drive(1'b1, bt(16'h0004, 16'h0003), 1'b0, 1'b0);
        drive(1'b1, bt(16'h0006, 16'h0005), 1'b0, 1'b0);
        check_model("b3");
        chk("b3_line_const", bus.write_buffer_read_out, 96'h0006_0005_0004_0003_0002_0001);
        chk("b3_valid_const", LINE_WIDTH'(bus.write_buffer_valid_out), 1);

        // Beat while full without ack is dropped.
        drive(1'b1, bt(16'h1234, 16'h5678), 1'b0, 1'b0);
        check_model("ovf");
        chk("ovf_const", LINE_WIDTH'(bus.overflow_out), 1);
        chk("ovf_line_const", bus.write_buffer_read_out, 96'h0006_0005_0004_0003_0002_0001);
        drive(1'b0, '0, 1'b0, 1'b1);
        check_model("ack");
        chk("ack_valid_const", LINE_WIDTH'(bus.write_buffer_valid_out), 0);
        chk("ack_ovf_const", LINE_WIDTH'(bus.overflow_out), 1);

        // Partial line closed by flush.
        do_reset();
        drive(1'b1, bt(16'hBBBB, 16'hAAAA), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check_model("flush");
        chk("flush_line_const", bus.write_buffer_read_out, 96'h0000_0000_0000_0000_BBBB_AAAA);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        check_model("flush_empty");
        chk("flush_empty_valid", LINE_WIDTH'(bus.write_buffer_valid_out), 0);

        // Ack and beat in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, bt(16'(i+1), 16'(i+1)), 1'b0, 1'b0);
        drive(1'b1, bt(16'h0008, 16'h0007), 1'b0, 1'b1);
        check_model("ackbeat");
        chk("ackbeat_valid", LINE_WIDTH'(bus.write_buffer_valid_out), 0);
        chk("ackbeat_cnt",   LINE_WIDTH'(bus.fill_count_out), 1);
        chk("ackbeat_ovf",   LINE_WIDTH'(bus.overflow_out), 0);
        chk("ackbeat_slot0", LINE_WIDTH'(bus.write_buffer_read_out[BEAT_W-1:0]), 96'h0008_0007);

        // Asynchronous reset mid-line.
        do_reset();
        drive(1'b1, bt(16'hCAFE, 16'hF00D), 1'b0, 1'b0);
        drive(1'b1, bt(16'h1357, 16'h2468), 1'b0, 1'b0);
        chk("mid_cnt", LINE_WIDTH'(bus.fill_count_out), 2);
        rst_in = 1'b0;
        #1;
        chk("async_line", bus.write_buffer_read_out, '0);
        chk("async_cnt",  LINE_WIDTH'(bus.fill_count_out), '0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        drive(1'b1, bt(16'h0B0B, 16'h0A0A), 1'b0, 1'b0);
        drive(1'b1, bt(16'h0D0D, 16'h0C0C), 1'b0, 1'b0);
        drive(1'b1, bt(16'h0F0F, 16'h0E0E), 1'b0, 1'b0);
        check_model("fresh");
        chk("fresh_line_const", bus.write_buffer_read_out, 96'h0F0F_0E0E_0D0D_0C0C_0B0B_0A0A);

        // Random traffic, with a reset halfway to keep overflow from sticking.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drive($urandom_range(0, 99) < 60, BEAT_W'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            check_model("rnd");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
